// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared 7-segment decoder: blanking gaps between
// digits, leading-zero suppression, and display updates deferred to frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_CNT  = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Load,
  input  logic [4*NUM_DIGITS-1:0]   i_Value,
  input  logic                      i_Lz_En,
  output logic [3:0]                o_Binary,
  output logic [NUM_DIGITS-1:0]     o_Digit_En,
  output logic                      o_Frame_Done,
  output logic                      o_Pending,
  output logic                      o_Dbg_State
);

  localparam int CNT_MAX = (REFRESH_CNT > BLANK_CYCLES) ? REFRESH_CNT : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int VAL_W   = 4 * NUM_DIGITS;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [VAL_W-1:0]        shadow;
  logic [VAL_W-1:0]        active;

  logic                    last_blank;
  logic                    last_show;
  logic                    boundary;
  logic [IDX_W-1:0]        next_idx;
  logic [VAL_W-1:0]        next_active;
  logic [3:0]              next_digit;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   onehot_idx;
  logic                    zero_above;

  assign o_Dbg_State = (state == SHOW);

  // i_Load is a fire-and-forget strobe with no back-pressure: every asserted cycle is
  // captured, and a later strobe simply replaces an earlier one not yet displayed.
  assign last_blank = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign last_show  = (cnt == CNT_W'(REFRESH_CNT - 1));
  assign boundary   = (state == SHOW) && last_show && (idx == IDX_W'(NUM_DIGITS - 1));
  assign next_idx   = boundary ? '0 : idx + IDX_W'(1);
  assign onehot_idx = NUM_DIGITS'(1) << idx;

  // A load coinciding with the boundary bypasses the shadow so it shows this frame.
  always_comb begin
    next_active = active;
    if (boundary) begin
      if (i_Load)
        next_active = i_Value;
      else if (o_Pending)
        next_active = shadow;
    end
  end

  always_comb begin
    next_digit = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (next_idx == IDX_W'(k))
        next_digit = next_active[4*k +: 4];
    end
  end

  // Digit 0 is never masked so an all-zero value still shows a single 0.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (active[4*k +: 4] == 4'd0);
      lz_mask[k] = i_Lz_En & zero_above;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      active       <= '0;
      o_Pending    <= 1'b0;
      o_Binary     <= 4'd0;
      o_Digit_En   <= '0;
      o_Frame_Done <= 1'b0;
    end else begin
      o_Frame_Done <= 1'b0;
      if (i_Load && !boundary) begin
        shadow    <= i_Value;
        o_Pending <= 1'b1;
      end
      case (state)
        BLANK: begin
          if (last_blank) begin
            state      <= SHOW;
            cnt        <= '0;
            o_Digit_En <= onehot_idx & ~lz_mask;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (last_show) begin
            state      <= BLANK;
            cnt        <= '0;
            o_Digit_En <= '0;
            idx        <= next_idx;
            o_Binary   <= next_digit;
            if (boundary) begin
              o_Frame_Done <= 1'b1;
              active       <= next_active;
              o_Pending    <= 1'b0;
              if (i_Load)
                shadow <= i_Value;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with 4 digits, 4-cycle refresh and 2-cycle blanking
// (24-cycle frame); a frame-position model predicts every output each cycle.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RC + BC;
  localparam int FRAME = ND * SLOT;

  logic          i_Clk;
  logic          i_Reset;
  logic          i_Load;
  logic [15:0]   i_Value;
  logic          i_Lz_En;
  logic [3:0]    o_Binary;
  logic [ND-1:0] o_Digit_En;
  logic          o_Frame_Done;
  logic          o_Pending;
  logic          o_Dbg_State;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_CNT (RC),
    .BLANK_CYCLES(BC)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Load      (i_Load),
    .i_Value     (i_Value),
    .i_Lz_En     (i_Lz_En),
    .o_Binary    (o_Binary),
    .o_Digit_En  (o_Digit_En),
    .o_Frame_Done(o_Frame_Done),
    .o_Pending   (o_Pending),
    .o_Dbg_State (o_Dbg_State)
  );

  // clock / reset
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int checks;
  int failures;

  // model: cycles since reset release, value shown this frame, shadow/pending, sampled lz
  int          m_k;
  logic [15:0] m_frame_val;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic        m_lz;
  logic [3:0]  prev_bin;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  exp_mask;
    logic [15:0] exp_bin;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t k=%0d)", name, act, exp, $time, m_k);
    end
  endtask

  function automatic logic [3:0] dig(input logic [15:0] v, input int d);
    return 4'((v >> (4 * d)) & 16'hF);
  endfunction

  function automatic logic [3:0] model_mask(input logic [15:0] v, input logic lz);
    logic [3:0] m;
    m = 4'b0;
    for (int k = 1; k < ND; k++)
      if (lz && ((v >> (4 * k)) == 16'd0)) m[k] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_frame_val = 16'h0;
    m_shadow = 16'h0;
    m_pending = 1'b0;
    m_lz = 1'b0;
    prev_bin = 4'h0;
  endtask

  task automatic model_update(input logic ld, input logic [15:0] v, input logic lz);
    int s;
    m_k++;
    s = m_k % FRAME;
    if (s == 0) begin
      if (ld) begin
        m_frame_val = v;
        m_shadow = v;
      end else if (m_pending) begin
        m_frame_val = m_shadow;
      end
      m_pending = 1'b0;
    end else if (ld) begin
      m_shadow = v;
      m_pending = 1'b1;
    end
    if (s % SLOT == BC) m_lz = lz;
  endtask

  task automatic check_outputs();
    int s, d, w;
    logic [3:0] exp_en;
    s = m_k % FRAME;
    d = s / SLOT;
    w = s % SLOT;
    exp_en = (w >= BC) ? (4'(1 << d) & ~model_mask(m_frame_val, m_lz)) : 4'b0;
    chk("digit_en", 32'(o_Digit_En), 32'(exp_en));
    chk("binary", 32'(o_Binary), 32'(dig(m_frame_val, d)));
    chk("frame_done", 32'(o_Frame_Done), 32'(m_k > 0 && s == 0));
    chk("pending", 32'(o_Pending), 32'(m_pending));
    chk("dbg_state", 32'(o_Dbg_State), 32'(w >= BC));
    chk("onehot0", 32'($onehot0(o_Digit_En)), 32'd1);
    if (o_Binary != prev_bin) chk("binary_change_while_on", 32'(o_Digit_En), 32'd0);
    prev_bin = o_Binary;
  endtask

  // driver: inputs present before the edge are what the edge samples
  task automatic tick();
    logic ld;
    logic [15:0] v;
    logic lz;
    ld = i_Load;
    v = i_Value;
    lz = i_Lz_En;
    @(posedge i_Clk);
    model_update(ld, v, lz);
    #1;
    check_outputs();
    i_Load = 1'b0;
  endtask

  task automatic run_to_slot(input int t);
    for (int i = 0; i < FRAME && (m_k % FRAME) != t; i++) tick();
    chk("run_to_slot", 32'(m_k % FRAME), 32'(t));
  endtask

  task automatic observe_frame(output logic [3:0] mask, output logic [15:0] bin);
    int s;
    mask = 4'b0;
    bin = 16'h0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      s = m_k % FRAME;
      if (s != 0) begin
        if (o_Digit_En[s / SLOT]) mask[s / SLOT] = 1'b1;
        if (s % SLOT == BC + 1) bin[4 * (s / SLOT) +: 4] = o_Binary;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_binary"}, 32'(o_Binary), 32'd0);
    chk({tag, "_digit_en"}, 32'(o_Digit_En), 32'd0);
    chk({tag, "_frame_done"}, 32'(o_Frame_Done), 32'd0);
    chk({tag, "_pending"}, 32'(o_Pending), 32'd0);
  endtask

  initial begin
    logic [3:0]  obs_mask;
    logic [15:0] obs_bin;
    logic        seen_one;

    checks = 0;
    failures = 0;
    vecs[0] = '{value: 16'h1234, lz: 1'b0, exp_mask: 4'b1111, exp_bin: 16'h1234};
    vecs[1] = '{value: 16'h0042, lz: 1'b1, exp_mask: 4'b0011, exp_bin: 16'h0042};
    vecs[2] = '{value: 16'h0000, lz: 1'b1, exp_mask: 4'b0001, exp_bin: 16'h0000};
    vecs[3] = '{value: 16'h0102, lz: 1'b1, exp_mask: 4'b0111, exp_bin: 16'h0102};
    vecs[4] = '{value: 16'h9000, lz: 1'b1, exp_mask: 4'b1111, exp_bin: 16'h9000};
    vecs[5] = '{value: 16'h00AF, lz: 1'b1, exp_mask: 4'b0011, exp_bin: 16'h00AF};
    vecs[6] = '{value: 16'h0042, lz: 1'b0, exp_mask: 4'b1111, exp_bin: 16'h0042};

    i_Reset = 1'b1;
    i_Load = 1'b0;
    i_Value = 16'h0;
    i_Lz_En = 1'b0;
    model_reset();
    #23;
    check_reset_outputs("reset");
    chk("reset_dbg_state", 32'(o_Dbg_State), 32'd0);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    // idle scan: first enable after BLANK_CYCLES edges, two frames of zeros
    tick();
    tick();
    chk("first_enable", 32'(o_Digit_En), 32'd1);
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // table: mid-frame load, applied at the boundary, observed over the next frame
    foreach (vecs[i]) begin
      i_Lz_En = vecs[i].lz;
      run_to_slot(10);
      i_Load = 1'b1;
      i_Value = vecs[i].value;
      tick();
      chk("pending_after_load", 32'(o_Pending), 32'd1);
      run_to_slot(0);
      chk("pending_after_boundary", 32'(o_Pending), 32'd0);
      observe_frame(obs_mask, obs_bin);
      chk("vec_mask", 32'(obs_mask), 32'(vecs[i].exp_mask));
      chk("vec_binary", 32'(obs_bin), 32'(vecs[i].exp_bin));
    end

    // two loads in one frame: only the last is ever displayed
    i_Lz_En = 1'b0;
    run_to_slot(5);
    i_Load = 1'b1;
    i_Value = 16'h1111;
    tick();
    run_to_slot(15);
    i_Load = 1'b1;
    i_Value = 16'h5678;
    tick();
    seen_one = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (o_Digit_En != 0 && o_Binary == 4'h1) seen_one = 1'b1;
    end
    chk("last_load_wins", 32'(seen_one), 32'd0);

    // load landing on the boundary edge bypasses the shadow
    run_to_slot(FRAME - 1);
    i_Load = 1'b1;
    i_Value = 16'h0042;
    tick();
    chk("bypass_frame_done", 32'(o_Frame_Done), 32'd1);
    chk("bypass_pending", 32'(o_Pending), 32'd0);
    chk("bypass_binary", 32'(o_Binary), 32'd2);
    observe_frame(obs_mask, obs_bin);
    chk("bypass_frame_binary", 32'(obs_bin), 32'h0042);

    // reset during SHOW of digit 2 with a load pending
    run_to_slot(12);
    i_Load = 1'b1;
    i_Value = 16'h9999;
    tick();
    run_to_slot(15);
    chk("pre_reset_pending", 32'(o_Pending), 32'd1);
    chk("pre_reset_enable", 32'(o_Digit_En), 32'd4);
    #3;
    i_Reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge i_Clk);
    i_Reset = 1'b0;
    observe_frame(obs_mask, obs_bin);
    chk("post_reset_binary", 32'(obs_bin), 32'h0);
    chk("post_reset_pending", 32'(o_Pending), 32'd0);

    // randomized traffic against the model, with boundary-edge loads forced in
    for (int i = 0; i < 40 * FRAME; i++) begin
      i_Load = ($urandom_range(0, 11) == 0) ||
               ((m_k % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0);
      i_Value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) i_Value[15:8] = 8'h00;
      if ($urandom_range(0, 15) == 0) i_Lz_En = ~i_Lz_En;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
